// File: rtl/rpi_serial_ctrl_if.sv
// RPi-side serial bus of the TIPI control bridge: shift clock, data, latch, register select and readback data.
interface rpi_serial_ctrl_if;
  logic       rpi_sclk;
  logic       rpi_sdata;
  logic       rpi_le;
  logic [1:0] rpi_regsel;
  logic       rpi_sdo;

  modport master (output rpi_sclk, rpi_sdata, rpi_le, rpi_regsel, input rpi_sdo);
  modport slave  (input rpi_sclk, rpi_sdata, rpi_le, rpi_regsel, output rpi_sdo);
endinterface

// File: rtl/rpi_serial_ctrl.sv
// RPi serial bridge: shifts 8-bit frames into rd_q/rc_q and serialises TI readback on rpi_sdo (option TIPI_TC_CHANGE_EN adds tc_changed).
// Latency: 3 clk from pin edge to state/register/strobe update; rpi_sdo follows the readback snapshot 1 clk later.
// No backpressure: the RPi must hold sclk/le phases for at least 4 clk; malformed frames only raise frame_err.
module rpi_serial_ctrl (
  input  logic             clk,
  input  logic             rst,
  rpi_serial_ctrl_if.slave rpi,
  input  logic [7:0]       ti_td,
  input  logic [7:0]       ti_tc,
  output logic [7:0]       rd_q,
  output logic [7:0]       rc_q,
  output logic             rd_strobe,
  output logic             rc_strobe,
  output logic             busy,
`ifdef TIPI_TC_CHANGE_EN
  output logic             tc_changed,
`endif
  output logic             frame_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_FULL    = 2'd2,
    ST_OVERRUN = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [1:0] sclk_sync;
  logic [1:0] sdata_sync;
  logic [1:0] le_sync;
  logic [1:0] regsel_s1;
  logic [1:0] regsel_s2;
  logic       sclk_d;
  logic       le_d;

  logic       sclk_rise;
  logic       le_rise;
  logic       sdata_s;

  logic [2:0] bit_cnt;
  logic [7:0] shift_q;
  logic [7:0] snap_q;
  logic [7:0] rb_sel;

  logic       shift_en;
  logic       commit;
  logic       le_err;
  logic       overrun_set;

  // Two-flop synchronisers plus one delay stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync  <= 2'b00;
      sdata_sync <= 2'b00;
      le_sync    <= 2'b00;
      regsel_s1  <= 2'b00;
      regsel_s2  <= 2'b00;
      sclk_d     <= 1'b0;
      le_d       <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[0], rpi.rpi_sclk};
      sdata_sync <= {sdata_sync[0], rpi.rpi_sdata};
      le_sync    <= {le_sync[0], rpi.rpi_le};
      regsel_s1  <= rpi.rpi_regsel;
      regsel_s2  <= regsel_s1;
      sclk_d     <= sclk_sync[1];
      le_d       <= le_sync[1];
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign le_rise   = le_sync[1] & ~le_d;
  assign sdata_s   = sdata_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A latch edge always wins over a coincident shift edge.
  always_comb begin
    state_nxt = state;
    if (le_rise) begin
      state_nxt = ST_IDLE;
    end else if (sclk_rise) begin
      case (state)
        ST_IDLE:  state_nxt = ST_SHIFT;
        ST_SHIFT: if (bit_cnt == 3'd7) state_nxt = ST_FULL;
        ST_FULL:  state_nxt = ST_OVERRUN;
        default:  state_nxt = state;
      endcase
    end
  end

  always_comb begin
    busy        = (state != ST_IDLE);
    shift_en    = sclk_rise & ~le_rise & ((state == ST_IDLE) | (state == ST_SHIFT));
    overrun_set = sclk_rise & ~le_rise & (state == ST_FULL);
    commit      = le_rise & (state == ST_FULL);
    le_err      = le_rise & ((state == ST_IDLE) | (state == ST_SHIFT));
  end

  always_comb begin
    rb_sel = rd_q;
    case (regsel_s2)
      2'b00:   rb_sel = rd_q;
      2'b01:   rb_sel = rc_q;
      2'b10:   rb_sel = ti_td;
      default: rb_sel = ti_tc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt     <= 3'd0;
      shift_q     <= 8'h00;
      snap_q      <= 8'h00;
      rpi.rpi_sdo <= 1'b0;
    end else begin
      if (le_rise) begin
        bit_cnt <= 3'd0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (shift_en) begin
        shift_q <= {shift_q[6:0], sdata_s};
      end

      // Snapshot tracks the selected register while idle, then freezes and drains MSB first.
      if (shift_en) begin
        snap_q <= {snap_q[6:0], 1'b0};
      end else if (state == ST_IDLE) begin
        snap_q <= rb_sel;
      end

      rpi.rpi_sdo <= snap_q[7];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q      <= 8'h00;
      rc_q      <= 8'h00;
      rd_strobe <= 1'b0;
      rc_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rd_strobe <= commit & (regsel_s2 == 2'b00);
      rc_strobe <= commit & (regsel_s2 == 2'b01);

      if (commit && (regsel_s2 == 2'b00)) begin
        rd_q <= shift_q;
      end
      if (commit && (regsel_s2 == 2'b01)) begin
        rc_q <= shift_q;
      end

      if (commit) begin
        frame_err <= 1'b0;
      end else if (le_err || overrun_set) begin
        frame_err <= 1'b1;
      end
    end
  end

`ifdef TIPI_TC_CHANGE_EN
  logic [7:0] tc_prev;

  // A fresh change outranks a coincident TC readback commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tc_prev    <= 8'h00;
      tc_changed <= 1'b0;
    end else begin
      tc_prev <= ti_tc;
      if (ti_tc != tc_prev) begin
        tc_changed <= 1'b1;
      end else if (commit && (regsel_s2 == 2'b11)) begin
        tc_changed <= 1'b0;
      end
    end
  end
`endif

endmodule
